// File: rtl/snn_ctrl_pkg.sv
// Shared types and constants for the SNN convolution-layer control path.
//   seq_state_t : sequencer FSM states
//   stage_t     : identifies one of the three per-timestep stages
//   CONV_SEL / POOL_SEL : encodings of the conv/pool arbiter select
package snn_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        CONV,
        POOL,
        NEXT,
        FINISH,
        ERROR
    } seq_state_t;

    typedef enum logic [1:0] {
        STG_CAPTURE,
        STG_CONV,
        STG_POOL
    } stage_t;

    localparam logic CONV_SEL = 1'b1;
    localparam logic POOL_SEL = 1'b0;

    // True for the states that are guarded by the watchdog.
    function automatic logic is_stage(input seq_state_t s);
        return (s == CAPTURE) || (s == CONV) || (s == POOL);
    endfunction

endpackage

// File: rtl/snn_stage_watchdog.sv
// Per-stage watchdog: counts cycles spent in the current stage.
//   clk_i     : system clock
//   reset_i   : synchronous active-high reset
//   clear_i   : restart the count (stage entry or exit)
//   freeze_i  : hold the count and suppress expiry
//   run_i     : a guarded stage is current
//   expire_o  : count has reached TIMEOUT_CYCLES-1 in a running, unfrozen cycle
module snn_stage_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned WD_W           = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic freeze_i,
    input  logic run_i,
    output logic expire_o
);

    localparam logic [WD_W-1:0] LastCount = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (run_i && !freeze_i) begin
            count_d = count_q + WD_W'(1);
        end
    end

    // The count equals the number of unfrozen cycles already spent in the stage,
    // so expiry fires during the TIMEOUT_CYCLES-th such cycle.
    assign expire_o = run_i && !freeze_i && (count_q == LastCount);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/snn_layer_sequencer.sv
// Top-side sequencer for the SNN convolution layer: steps capture -> conv -> pool
// once per timestep for TIMESTEPS timesteps, with a watchdog on every stage.
//   clk_i, reset_i          : clock, synchronous active-high reset
//   start_i, pause_i        : run request (IDLE only), stage-boundary hold
//   cap_enable_o/cap_active_i                 : capture stage handshake
//   conv_enable_o/conv_active_i/conv_ready_i  : convolution stage handshake
//   pool_enable_o/pool_active_i/pool_done_i   : pooling stage handshake
//   conv_or_pool_o          : arbiter select (1 = conv, 0 = pool)
//   busy_o, done_o          : not-idle level, end-of-run pulse
//   timeout_err_o           : sticky watchdog error
//   timestep_o              : current timestep index
module snn_layer_sequencer
    import snn_ctrl_pkg::*;
#(
    parameter int unsigned TIMESTEPS      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TS_W           = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1,
    parameter int unsigned WD_W           = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            pause_i,
    output logic            cap_enable_o,
    input  logic            cap_active_i,
    output logic            conv_enable_o,
    input  logic            conv_active_i,
    input  logic            conv_ready_i,
    output logic            pool_enable_o,
    input  logic            pool_active_i,
    input  logic            pool_done_i,
    output logic            conv_or_pool_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            timeout_err_o,
    output logic [TS_W-1:0] timestep_o
);

    localparam logic [TS_W-1:0] LastTs = TS_W'(TIMESTEPS - 1);

    seq_state_t      state_q, state_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            seen_q, seen_d;
    logic            stage_clear;
    logic            wd_expire;

    logic cap_enable_q, conv_enable_q, pool_enable_q, conv_or_pool_q;
    logic busy_q, done_q, timeout_err_q;

    // Stage busy levels are informational; completion is judged from other returns.
    logic unused_returns;
    assign unused_returns = conv_active_i ^ pool_active_i;

    snn_stage_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .WD_W          (WD_W)
    ) u_watchdog (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (stage_clear),
        .freeze_i(pause_i),
        .run_i   (is_stage(state_q)),
        .expire_o(wd_expire)
    );

    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        seen_d  = seen_q;
        unique case (state_q)
            IDLE: begin
                if (start_i && !pause_i) begin
                    state_d = CAPTURE;
                    ts_d    = '0;
                end
            end
            // Completion is tested before expiry so a same-cycle completion wins.
            CAPTURE: begin
                if (seen_q && !cap_active_i) begin
                    state_d = CONV;
                end else if (wd_expire) begin
                    state_d = ERROR;
                end else if (cap_active_i) begin
                    seen_d = 1'b1;
                end
            end
            CONV: begin
                if (conv_ready_i) begin
                    state_d = POOL;
                end else if (wd_expire) begin
                    state_d = ERROR;
                end
            end
            POOL: begin
                if (pool_done_i) begin
                    state_d = NEXT;
                end else if (wd_expire) begin
                    state_d = ERROR;
                end
            end
            NEXT: begin
                if (!pause_i) begin
                    if (ts_q == LastTs) begin
                        state_d = FINISH;
                    end else begin
                        ts_d    = ts_q + TS_W'(1);
                        state_d = CAPTURE;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase

        // Any state change is a stage boundary: restart the watchdog and capture tracking.
        stage_clear = (state_d != state_q);
        if (stage_clear) begin
            seen_d = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            ts_q           <= '0;
            seen_q         <= 1'b0;
            cap_enable_q   <= 1'b0;
            conv_enable_q  <= 1'b0;
            pool_enable_q  <= 1'b0;
            conv_or_pool_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            ts_q           <= ts_d;
            seen_q         <= seen_d;
            cap_enable_q   <= (state_d == CAPTURE);
            conv_enable_q  <= (state_d == CONV);
            pool_enable_q  <= (state_d == POOL);
            conv_or_pool_q <= (state_d == CONV) ? CONV_SEL : POOL_SEL;
            busy_q         <= (state_d != IDLE);
            done_q         <= (state_d == FINISH);
            timeout_err_q  <= (state_d == ERROR);
        end
    end

    assign cap_enable_o   = cap_enable_q;
    assign conv_enable_o  = conv_enable_q;
    assign pool_enable_o  = pool_enable_q;
    assign conv_or_pool_o = conv_or_pool_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign timeout_err_o  = timeout_err_q;
    assign timestep_o     = ts_q;

endmodule

// File: doc/snn_layer_sequencer.md
Name: snn_layer_sequencer

Overview:
Top-side controller for the SNN convolution layer control interface. It generates the enable levels for the capture, convolution and pooling stages, and it drives the conv/pool arbiter select. It watches each stage's active/ready/done returns and steps through all three stages once per timestep for TIMESTEPS timesteps. Each stage is guarded by a watchdog. The block sits between the host/top controller and the stage modules.

Parameters:
TIMESTEPS, 16, timesteps per run; must be >= 1.
TIMEOUT_CYCLES, 4096, maximum cycles allowed in any one stage before an error; must be >= 2.
TS_W, $clog2(TIMESTEPS) (minimum 1), width of the timestep index.
WD_W, $clog2(TIMEOUT_CYCLES), width of the watchdog counter.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
start  in  1  run request; sampled only in IDLE.
pause  in  1  holds the sequencer at stage boundaries; freezes the watchdog.
cap_enable  out  1  enable level to the capture stage.
cap_active  in  1  capture stage busy.
conv_enable  out  1  enable level to the convolution stage.
conv_active  in  1  convolution stage busy.
conv_ready  in  1  convolution result ready.
pool_enable  out  1  enable level to the pooling stage.
pool_active  in  1  pooling stage busy.
pool_done  in  1  pooling complete.
conv_or_pool  out  1  arbiter select: 1 = conv, 0 = pool.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at the end of a run.
timeout_err  out  1  sticky watchdog error flag.
timestep  out  TS_W  index of the current timestep.

Behaviour:
- All outputs are registered. Reset is synchronous: state -> IDLE; every output, counter and seen_active flag -> 0. Reset mid-run behaves the same and takes effect on the next edge.
- FSM states: IDLE, CAPTURE, CONV, POOL, NEXT, FINISH, ERROR.
- IDLE:
  - start=1 && pause=0 -> CAPTURE, timestep=0.
  - cap_enable is high in the cycle after start is sampled (latency 1).
- CAPTURE:
  - cap_enable=1.
  - seen_active is set when cap_active=1.
  - Complete when seen_active && cap_active=0 (falling edge) -> CONV.
- CONV:
  - conv_enable=1 and conv_or_pool=1.
  - Complete when conv_ready=1 -> POOL.
- POOL:
  - pool_enable=1 and conv_or_pool=0.
  - Complete when pool_done=1 -> NEXT.
- NEXT:
  - Held while pause=1.
  - If timestep==TIMESTEPS-1 -> FINISH; else timestep++ and -> CAPTURE.
- FINISH: done=1 for exactly one cycle -> IDLE. timestep holds its last value until the next start.
- Enable timing: exactly one enable is high at any time, and only while its state is current. It deasserts on the cycle after the completion condition is sampled. conv_or_pool is 0 outside CONV.
- seen_active and the watchdog clear on every stage entry.
- Watchdog:
  - Counts cycles spent in CAPTURE, CONV and POOL; does not advance while pause=1.
  - On reaching TIMEOUT_CYCLES-1 without completion -> ERROR.
  - If a completion and the expiry occur in the same cycle, the completion wins.
- Pause:
  - Blocks the IDLE->CAPTURE and NEXT transitions only.
  - Stage completions during pause are still honoured, so no return pulses are lost.
- ERROR:
  - All enables are 0, busy=1, timeout_err=1.
  - Exited only by reset; start is ignored.
- start while busy=1 is ignored.
- Returns from a stage that is not current (e.g. a stray pool_done during CONV) are ignored.
- TIMESTEPS=1: NEXT goes straight to FINISH; timestep stays 0.

Decomposition:
- Package snn_ctrl_pkg:
  - enum seq_state_t {IDLE, CAPTURE, CONV, POOL, NEXT, FINISH, ERROR}.
  - Constants CONV_SEL=1'b1 and POOL_SEL=1'b0.
  - Shared stage_t enum {STG_CAPTURE, STG_CONV, STG_POOL}.
- One sub-module, snn_stage_watchdog:
  - Inputs: clear, freeze, run.
  - Output: expire.
  - Parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Basic run: TIMESTEPS=2; stubs respond with active for 3 cycles, then ready/done. start pulse -> cap, conv, pool enables in order twice; timestep goes 0 then 1; done pulses once; busy falls in the cycle after done.
2. Latency and exclusivity: start at cycle 10 -> cap_enable=1 at cycle 11. At no cycle is more than one enable high. conv_or_pool=1 only while conv_enable=1.
3. Watchdog: TIMEOUT_CYCLES=8 and conv_ready never asserted -> ERROR at the 8th CONV cycle; all enables 0; timeout_err=1 held. A later start is ignored. reset clears everything to 0.
4. Pause: assert pause during POOL -> pool_done is still accepted. The sequencer waits in NEXT with no enable high; the watchdog is frozen. Releasing pause -> CAPTURE next cycle with timestep incremented.
5. Same-cycle race: conv_ready asserted exactly on the expiry cycle -> POOL entered and timeout_err stays 0.
6. Reset mid-run: assert reset during CONV of timestep 3 -> next cycle all outputs 0 and state IDLE. A fresh start then restarts from timestep=0.
